// File: rtl/int_to_float_if.sv
// Start/busy/done handshake and operand/result bus for the iterative int-to-float converter.
interface int_to_float_if;
    logic        start;
    logic [31:0] in_int;
    logic        busy;
    logic        done;
    logic [31:0] value;

    modport master (output start, output in_int, input busy, input done, input value);
    modport slave  (input start, input in_int, output busy, output done, output value);
endinterface

// File: rtl/int_to_float.sv
// Iterative signed 32-bit integer to IEEE-754 single converter.
// Normalises SHIFT bits per cycle, then rounds (RNE or truncate) in a single step.
module int_to_float #(
    parameter int unsigned SHIFT    = 1,
    parameter bit          ROUND_EN = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    int_to_float_if.slave  cvt
);

    localparam int unsigned MAG_W   = 32;
    localparam int unsigned EXP_W   = 9;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned SH_W    = 4;
    localparam logic [EXP_W-1:0] EXP_BIAS_TOP = 9'd158;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              sign_q,  sign_d;
    logic [MAG_W-1:0]  mag_q,   mag_d;
    logic [EXP_W-1:0]  exp_q,   exp_d;
    logic [31:0]       value_q, value_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [SH_W-1:0]   sh_amt;
    logic              sh_hit;
    logic [MANT_W-1:0] mant;
    logic              rnd_g;
    logic              rnd_s;
    logic              rnd_inc;
    logic [MANT_W:0]   mant_sum;
    logic [MANT_W-1:0] mant_r;
    logic [EXP_W-1:0]  exp_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            value_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            value_q <= value_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        value_d = value_q;

        // Shift by min(SHIFT, leading zeros) so mag[31] is never overshot
        sh_amt = '0;
        sh_hit = 1'b0;
        for (int unsigned i = 0; i < SHIFT; i++) begin
            if (!sh_hit) begin
                if (!mag_q[MAG_W-1-i]) begin
                    sh_amt = SH_W'(i + 1);
                end else begin
                    sh_hit = 1'b1;
                end
            end
        end

        mant     = mag_q[30:8];
        rnd_g    = mag_q[7];
        rnd_s    = |mag_q[6:0];
        rnd_inc  = ROUND_EN && rnd_g && (rnd_s || mant[0]);
        mant_sum = {1'b0, mant} + (MANT_W+1)'(rnd_inc);
        if (mant_sum[MANT_W]) begin
            mant_r = '0;
            exp_r  = exp_q + 9'd1;
        end else begin
            mant_r = mant_sum[MANT_W-1:0];
            exp_r  = exp_q;
        end

        case (state_q)
            IDLE: begin
                if (cvt.start) begin
                    sign_d  = cvt.in_int[31];
                    mag_d   = cvt.in_int[31] ? MAG_W'(-cvt.in_int) : cvt.in_int;
                    exp_d   = EXP_BIAS_TOP;
                    state_d = NORM;
                end
            end
            NORM: begin
                // A zero operand passes through here for one non-busy cycle
                if (mag_q == '0) begin
                    value_d = '0;
                    state_d = DONE;
                end else if (mag_q[MAG_W-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << sh_amt;
                    exp_d = exp_q - EXP_W'(sh_amt);
                end
            end
            ROUND: begin
                value_d = {sign_q, exp_r[7:0], mant_r};
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = ((state_d == NORM) && (mag_d != '0)) || (state_d == ROUND);
        done_d = (state_d == DONE);
    end

    assign cvt.busy  = busy_q;
    assign cvt.done  = done_q;
    assign cvt.value = value_q;

endmodule

// File: tb/tb_int_to_float.sv
// Directed bench for int_to_float: three instances (SHIFT=1 RNE, SHIFT=4 RNE, SHIFT=1 truncate).
module tb_int_to_float;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [31:0] in_v;
    int          sel;
    logic        o_done;
    logic        o_busy;
    logic [31:0] o_value;
    int          checks;
    int          failures;

    int_to_float_if if_a ();
    int_to_float_if if_b ();
    int_to_float_if if_c ();

    assign if_a.start  = start_v[0];
    assign if_b.start  = start_v[1];
    assign if_c.start  = start_v[2];
    assign if_a.in_int = in_v;
    assign if_b.in_int = in_v;
    assign if_c.in_int = in_v;

    int_to_float #(.SHIFT(1), .ROUND_EN(1'b1)) dut_a (.clk(clk), .reset(reset), .cvt(if_a.slave));
    int_to_float #(.SHIFT(4), .ROUND_EN(1'b1)) dut_b (.clk(clk), .reset(reset), .cvt(if_b.slave));
    int_to_float #(.SHIFT(1), .ROUND_EN(1'b0)) dut_c (.clk(clk), .reset(reset), .cvt(if_c.slave));

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1: begin
                o_done = if_b.done; o_busy = if_b.busy; o_value = if_b.value;
            end
            2: begin
                o_done = if_c.done; o_busy = if_c.busy; o_value = if_c.value;
            end
            default: begin
                o_done = if_a.done; o_busy = if_a.busy; o_value = if_a.value;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at a negedge, DUT idle again
    task automatic run(input int which, input logic [31:0] op, input logic [31:0] exp_val,
                       input int exp_lat, input int glitch_at, input string tag);
        int   lat;
        logic busy_seen;
        sel            = which;
        in_v           = op;
        start_v[which] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[which] = 1'b0;
        in_v           = 32'hDEAD_BEEF;
        lat            = 0;
        busy_seen      = 1'b0;
        while (!o_done && lat < 100) begin
            if (o_busy) busy_seen = 1'b1;
            if (lat == glitch_at) begin
                in_v           = 32'h7FFF_FFFF;
                start_v[which] = 1'b1;
            end else begin
                start_v[which] = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        start_v[which] = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " value"}, o_value, exp_val);
        chk({tag, " busy_seen"}, {31'b0, busy_seen}, {31'b0, op != 32'h0});
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'b0, o_done}, 32'h0);
        chk({tag, " value_held"}, o_value, exp_val);
    endtask

    initial begin
        logic done_seen;
        checks   = 0;
        failures = 0;
        sel      = 0;
        start_v  = 3'b000;
        in_v     = 32'h0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst value_a", if_a.value, 32'h0);
        chk("rst busy_a", {31'b0, if_a.busy}, 32'h0);
        chk("rst done_a", {31'b0, if_a.done}, 32'h0);
        chk("rst value_b", if_b.value, 32'h0);
        chk("rst value_c", if_c.value, 32'h0);

        run(0, 32'h0000_03E8, 32'h447A_0000, 24, -1, "basic_1000");
        run(0, 32'hFFFF_FFF6, 32'hC120_0000, 30, -1, "neg_10");
        run(0, 32'h0000_0000, 32'h0000_0000, 1,  -1, "zero");
        run(0, 32'h7FFF_FFFF, 32'h4F00_0000, 3,  -1, "max_pos_carry");
        run(0, 32'h8000_0000, 32'hCF00_0000, 2,  -1, "min_neg");
        run(0, 32'h0100_0001, 32'h4B80_0000, 9,  -1, "tie_even");
        run(0, 32'h0100_0003, 32'h4B80_0002, 9,  -1, "tie_up");
        run(0, 32'h0000_0001, 32'h3F80_0000, 33, -1, "one");

        run(2, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 3,  -1, "trunc_max");
        run(2, 32'h0100_0003, 32'h4B80_0001, 9,  -1, "trunc_tie");

        run(1, 32'h0000_03E8, 32'h447A_0000, 8,  -1, "sh4_1000");
        run(1, 32'h0000_0001, 32'h3F80_0000, 10, -1, "sh4_one");
        run(1, 32'h8000_0000, 32'hCF00_0000, 2,  -1, "sh4_min_neg");

        run(0, 32'h0000_03E8, 32'h447A_0000, 24, 5, "start_mid_norm");

        // Abort a conversion with reset: result cleared, no done afterwards
        sel        = 0;
        in_v       = 32'h0000_03E8;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort busy_before", {31'b0, if_a.busy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort value", if_a.value, 32'h0);
        chk("abort busy", {31'b0, if_a.busy}, 32'h0);
        chk("abort done", {31'b0, if_a.done}, 32'h0);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (if_a.done) done_seen = 1'b1;
        end
        chk("abort no_done", {31'b0, done_seen}, 32'h0);
        chk("abort value_stays", if_a.value, 32'h0);

        run(0, 32'hFFFF_FFF6, 32'hC120_0000, 30, -1, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
